// File: rtl/aq_bus_pkg.sv
// Shared definitions for the AQ bus initiator.
// Provides command opcode encodings, page-bank codes, the bus-cycle state
// enum and the default parameter values used by aq_bus_initiator.
package aq_bus_pkg;

  typedef enum logic [1:0] {
    OpMemRd   = 2'b00,
    OpMemWr   = 2'b01,
    OpIoWr    = 2'b10,
    OpSetPage = 2'b11
  } cmd_op_e;

  // Bank field of a SET_PAGE command (cmd_data[7:6]).
  localparam logic [1:0] BankNone = 2'b00;
  localparam logic [1:0] BankLo   = 2'b01;
  localparam logic [1:0] BankMid  = 2'b10;
  localparam logic [1:0] BankHi   = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StT1,
    StT2,
    StTw,
    StT3
  } state_e;

  localparam int unsigned DefWaitTimeout = 255;
  localparam logic [7:0]  DefPagePort    = 8'hE7;

  // IO_WR and SET_PAGE both run an IO write cycle.
  function automatic logic is_io(cmd_op_e op);
    return (op == OpIoWr) || (op == OpSetPage);
  endfunction

endpackage

// File: rtl/aq_bus_initiator.sv
// AQ bus initiator: turns single commands into Z80-style bus cycles.
// Ports:
//   aq_clk, aq_rst_n            clock (one T-state per cycle), async active-low reset
//   cmd_valid/cmd_ready         command handshake; cmd_op, cmd_addr, cmd_data payload
//   rsp_valid/rsp_data/rsp_err  one-cycle completion pulse with read data / error flag
//   aq_addr, aq_data_o/_oe/_i   address bus and split data bus
//   aq_mreq_n, aq_iorq_n,
//   aq_rd_n, aq_wr_n            active-low strobes
//   aq_wait_n                   active-low wait request
//   lo_page/mid_page/hi_page,
//   hi_enable                   shadow copy of the paged-RAM page register
module aq_bus_initiator
  import aq_bus_pkg::*;
#(
  parameter int unsigned WAIT_TIMEOUT = DefWaitTimeout,
  parameter logic [7:0]  PAGE_PORT    = DefPagePort
) (
  input  logic        aq_clk,
  input  logic        aq_rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_data,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        rsp_err,
  output logic [15:0] aq_addr,
  output logic [7:0]  aq_data_o,
  output logic        aq_data_oe,
  input  logic [7:0]  aq_data_i,
  output logic        aq_mreq_n,
  output logic        aq_iorq_n,
  output logic        aq_rd_n,
  output logic        aq_wr_n,
  input  logic        aq_wait_n,
  output logic [5:0]  lo_page,
  output logic [5:0]  mid_page,
  output logic [5:0]  hi_page,
  output logic        hi_enable
);

  localparam logic [7:0] TimeoutCnt = 8'(WAIT_TIMEOUT);

  state_e     state;
  cmd_op_e    op_q;
  logic [7:0] data_q;
  logic [7:0] wait_cnt;
  cmd_op_e    op_in;
  logic [7:0] wait_cnt_inc;
  logic       timed_out;

  assign op_in        = cmd_op_e'(cmd_op);
  assign cmd_ready    = (state == StIdle);
  assign wait_cnt_inc = (wait_cnt >= TimeoutCnt) ? wait_cnt : wait_cnt + 8'd1;
  // The counter only moves on wait-extension TWs, so a zero count in TW is the
  // mandatory IO wait state and never an abort.
  assign timed_out    = (wait_cnt != 8'd0) && (wait_cnt >= TimeoutCnt);

  always_ff @(posedge aq_clk or negedge aq_rst_n) begin
    if (!aq_rst_n) begin
      state      <= StIdle;
      op_q       <= OpMemRd;
      data_q     <= '0;
      wait_cnt   <= '0;
      aq_addr    <= '0;
      aq_data_o  <= '0;
      aq_data_oe <= 1'b0;
      aq_mreq_n  <= 1'b1;
      aq_iorq_n  <= 1'b1;
      aq_rd_n    <= 1'b1;
      aq_wr_n    <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_data   <= '0;
      lo_page    <= '0;
      mid_page   <= '0;
      hi_page    <= '0;
      hi_enable  <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      case (state)
        StIdle: begin
          if (cmd_valid) begin
            op_q     <= op_in;
            data_q   <= cmd_data;
            wait_cnt <= '0;
            if (op_in == OpSetPage && cmd_data[7:6] == BankNone) begin
              // Bank 00 is not a real page register: reject without a bus cycle.
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end else begin
              state      <= StT1;
              aq_addr    <= (op_in == OpSetPage) ? {8'h00, PAGE_PORT} : cmd_addr;
              aq_data_o  <= cmd_data;
              aq_mreq_n  <= is_io(op_in);
              aq_rd_n    <= (op_in != OpMemRd);
              aq_data_oe <= (op_in == OpMemWr);
            end
          end
        end
        StT1: begin
          state <= StT2;
          if (is_io(op_q)) begin
            aq_iorq_n  <= 1'b0;
            aq_wr_n    <= 1'b0;
            aq_data_oe <= 1'b1;
          end else if (op_q == OpMemWr) begin
            aq_wr_n <= 1'b0;
          end
        end
        StT2: begin
          if (!aq_wait_n) begin
            state    <= StTw;
            wait_cnt <= wait_cnt_inc;
          end else if (is_io(op_q)) begin
            state <= StTw;
          end else begin
            state <= StT3;
          end
        end
        StTw: begin
          if (timed_out) begin
            state      <= StIdle;
            wait_cnt   <= '0;
            aq_mreq_n  <= 1'b1;
            aq_iorq_n  <= 1'b1;
            aq_rd_n    <= 1'b1;
            aq_wr_n    <= 1'b1;
            aq_data_oe <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_err    <= 1'b1;
          end else if (!aq_wait_n) begin
            wait_cnt <= wait_cnt_inc;
          end else begin
            state <= StT3;
          end
        end
        StT3: begin
          state      <= StIdle;
          wait_cnt   <= '0;
          aq_mreq_n  <= 1'b1;
          aq_iorq_n  <= 1'b1;
          aq_rd_n    <= 1'b1;
          aq_wr_n    <= 1'b1;
          aq_data_oe <= 1'b0;
          rsp_valid  <= 1'b1;
          if (op_q == OpMemRd) begin
            rsp_data <= aq_data_i;
          end
          if (op_q == OpSetPage) begin
            case (data_q[7:6])
              BankLo:  lo_page  <= data_q[5:0];
              BankMid: mid_page <= data_q[5:0];
              BankHi: begin
                hi_page   <= data_q[5:0];
                hi_enable <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_aq_bus_initiator.sv
// Directed bench for aq_bus_initiator: a vector table of single commands with
// expected cycle counts and results, plus hand sequences for reset behaviour.
module tb_aq_bus_initiator;

  logic        aq_clk = 1'b0;
  logic        aq_rst_n = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [15:0] cmd_addr = '0;
  logic [7:0]  cmd_data = '0;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        rsp_err;
  logic [15:0] aq_addr;
  logic [7:0]  aq_data_o;
  logic        aq_data_oe;
  logic [7:0]  aq_data_i = '0;
  logic        aq_mreq_n;
  logic        aq_iorq_n;
  logic        aq_rd_n;
  logic        aq_wr_n;
  logic        aq_wait_n = 1'b1;
  logic [5:0]  lo_page;
  logic [5:0]  mid_page;
  logic [5:0]  hi_page;
  logic        hi_enable;

  aq_bus_initiator #(
    .WAIT_TIMEOUT(4),
    .PAGE_PORT   (8'hE7)
  ) dut (
    .aq_clk    (aq_clk),
    .aq_rst_n  (aq_rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .aq_addr   (aq_addr),
    .aq_data_o (aq_data_o),
    .aq_data_oe(aq_data_oe),
    .aq_data_i (aq_data_i),
    .aq_mreq_n (aq_mreq_n),
    .aq_iorq_n (aq_iorq_n),
    .aq_rd_n   (aq_rd_n),
    .aq_wr_n   (aq_wr_n),
    .aq_wait_n (aq_wait_n),
    .lo_page   (lo_page),
    .mid_page  (mid_page),
    .hi_page   (hi_page),
    .hi_enable (hi_enable)
  );

  always #5 aq_clk = ~aq_clk;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] addr;
    logic [7:0]  data;
    logic [7:0]  rdata;
    int          wait_low;  // cycles, counted from T2, that aq_wait_n is held low
    int          lat;       // accept edge to rsp_valid cycle
    int          n_mreq;
    int          n_iorq;
    int          n_rd;
    int          n_wr;
    int          n_oe;
    logic        err;
    logic [7:0]  rdat;
    logic        chk_bus;   // a bus cycle runs, so address/data are checked
    logic [15:0] exp_addr;
    logic [5:0]  lo;
    logic [5:0]  mid;
    logic [5:0]  hi;
    logic        hien;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called one time unit after a rising edge with the DUT in IDLE; returns in the
  // response cycle, one time unit after its rising edge.
  task automatic run_vec(input int idx, input vec_t v);
    int          lat = 0;
    int          nm = 0, ni = 0, nr = 0, nw = 0, no = 0, busy_rdy = 0;
    logic [15:0] a1 = '0;
    logic [7:0]  d1 = '0;
    logic        err_s = 1'bx;
    logic [7:0]  rdat_s = 8'hxx;
    logic [5:0]  idle_s = 6'bxxxxxx;
    logic [18:0] shadow_s = 'x;
    cmd_op    = v.op;
    cmd_addr  = v.addr;
    cmd_data  = v.data;
    aq_data_i = v.rdata;
    aq_wait_n = 1'b1;
    cmd_valid = 1'b1;
    chk($sformatf("v%0d.ready_at_accept", idx), 32'(cmd_ready), 32'd1);
    for (int i = 1; i <= 30 && lat == 0; i++) begin
      @(posedge aq_clk);
      #1;
      cmd_valid = 1'b0;
      aq_wait_n = !(i >= 2 && i <= 1 + v.wait_low);
      if (i == 1) begin
        a1 = aq_addr;
        d1 = aq_data_o;
      end
      if (!aq_mreq_n) nm++;
      if (!aq_iorq_n) ni++;
      if (!aq_rd_n) nr++;
      if (!aq_wr_n) nw++;
      if (aq_data_oe) no++;
      if (rsp_valid) begin
        lat      = i;
        err_s    = rsp_err;
        rdat_s   = rsp_data;
        idle_s   = {aq_mreq_n, aq_iorq_n, aq_rd_n, aq_wr_n, aq_data_oe, cmd_ready};
        shadow_s = {lo_page, mid_page, hi_page, hi_enable};
      end else if (cmd_ready) begin
        busy_rdy++;
      end
    end
    aq_wait_n = 1'b1;
    chk($sformatf("v%0d.latency", idx), 32'(lat), 32'(v.lat));
    chk($sformatf("v%0d.mreq_low_cycles", idx), 32'(nm), 32'(v.n_mreq));
    chk($sformatf("v%0d.iorq_low_cycles", idx), 32'(ni), 32'(v.n_iorq));
    chk($sformatf("v%0d.rd_low_cycles", idx), 32'(nr), 32'(v.n_rd));
    chk($sformatf("v%0d.wr_low_cycles", idx), 32'(nw), 32'(v.n_wr));
    chk($sformatf("v%0d.oe_cycles", idx), 32'(no), 32'(v.n_oe));
    chk($sformatf("v%0d.ready_while_busy", idx), 32'(busy_rdy), 32'd0);
    chk($sformatf("v%0d.rsp_err", idx), 32'(err_s), 32'(v.err));
    chk($sformatf("v%0d.rsp_data", idx), 32'(rdat_s), 32'(v.rdat));
    chk($sformatf("v%0d.idle_outputs", idx), 32'(idle_s), 32'b111101);
    chk($sformatf("v%0d.shadow", idx), 32'(shadow_s),
        32'({v.lo, v.mid, v.hi, v.hien}));
    if (v.chk_bus) begin
      chk($sformatf("v%0d.aq_addr", idx), 32'(a1), 32'(v.exp_addr));
      chk($sformatf("v%0d.aq_data_o", idx), 32'(d1), 32'(v.data));
    end
  endtask

  vec_t vecs[12];
  int   rsp_seen;

  initial begin
    //         op     addr      data   rdata  wt  lat m  i  r  w  oe err rdat  bus addr
    vecs[0]  = '{2'd0, 16'h4123, 8'h00, 8'h5A, 0,   4, 3, 0, 3, 0, 0, 1'b0, 8'h5A, 1'b1,
                 16'h4123, 6'h00, 6'h00, 6'h00, 1'b0};
    vecs[1]  = '{2'd3, 16'h0000, 8'hC5, 8'h00, 0,   5, 0, 3, 0, 3, 3, 1'b0, 8'h5A, 1'b1,
                 16'h00E7, 6'h00, 6'h00, 6'h05, 1'b1};
    vecs[2]  = '{2'd1, 16'h8000, 8'h33, 8'h00, 2,   6, 5, 0, 0, 4, 5, 1'b0, 8'h5A, 1'b1,
                 16'h8000, 6'h00, 6'h00, 6'h05, 1'b1};
    vecs[3]  = '{2'd3, 16'h0000, 8'h12, 8'h00, 0,   1, 0, 0, 0, 0, 0, 1'b1, 8'h5A, 1'b0,
                 16'h0000, 6'h00, 6'h00, 6'h05, 1'b1};
    vecs[4]  = '{2'd2, 16'h00E7, 8'h15, 8'h00, 0,   5, 0, 3, 0, 3, 3, 1'b0, 8'h5A, 1'b1,
                 16'h00E7, 6'h00, 6'h00, 6'h05, 1'b1};
    vecs[5]  = '{2'd3, 16'h0000, 8'h47, 8'h00, 0,   5, 0, 3, 0, 3, 3, 1'b0, 8'h5A, 1'b1,
                 16'h00E7, 6'h07, 6'h00, 6'h05, 1'b1};
    vecs[6]  = '{2'd3, 16'h0000, 8'h8A, 8'h00, 0,   5, 0, 3, 0, 3, 3, 1'b0, 8'h5A, 1'b1,
                 16'h00E7, 6'h07, 6'h0A, 6'h05, 1'b1};
    vecs[7]  = '{2'd0, 16'h00FF, 8'h00, 8'hA5, 1,   5, 4, 0, 4, 0, 0, 1'b0, 8'hA5, 1'b1,
                 16'h00FF, 6'h07, 6'h0A, 6'h05, 1'b1};
    vecs[8]  = '{2'd3, 16'h0000, 8'hC0, 8'h00, 0,   5, 0, 3, 0, 3, 3, 1'b0, 8'hA5, 1'b1,
                 16'h00E7, 6'h07, 6'h0A, 6'h00, 1'b1};
    vecs[9]  = '{2'd2, 16'h1234, 8'h99, 8'h00, 0,   5, 0, 3, 0, 3, 3, 1'b0, 8'hA5, 1'b1,
                 16'h1234, 6'h07, 6'h0A, 6'h00, 1'b1};
    // Wait stuck low with a timeout of 4: four extension TWs, then abort.
    vecs[10] = '{2'd3, 16'h0000, 8'h4F, 8'h00, 100, 7, 0, 5, 0, 5, 5, 1'b1, 8'hA5, 1'b1,
                 16'h00E7, 6'h07, 6'h0A, 6'h00, 1'b1};
    vecs[11] = '{2'd0, 16'h2000, 8'h00, 8'h3C, 100, 7, 6, 0, 6, 0, 0, 1'b1, 8'hA5, 1'b1,
                 16'h2000, 6'h07, 6'h0A, 6'h00, 1'b1};

    // Reset state.
    #1 aq_rst_n = 1'b0;
    repeat (2) @(posedge aq_clk);
    #1;
    chk("reset.strobes_oe", 32'({aq_mreq_n, aq_iorq_n, aq_rd_n, aq_wr_n, aq_data_oe}),
        32'b11110);
    chk("reset.aq_addr", 32'(aq_addr), 32'h0);
    chk("reset.aq_data_o", 32'(aq_data_o), 32'h0);
    chk("reset.rsp", 32'({rsp_valid, rsp_err, rsp_data}), 32'h0);
    chk("reset.shadow", 32'({lo_page, mid_page, hi_page, hi_enable}), 32'h0);
    aq_rst_n = 1'b1;
    @(posedge aq_clk);
    #1;
    chk("reset.ready_after_release", 32'(cmd_ready), 32'd1);

    // Reset in T2 of SET_PAGE 8'h47: cycle abandoned, no response, no shadow update.
    cmd_op    = 2'd3;
    cmd_data  = 8'h47;
    cmd_valid = 1'b1;
    @(posedge aq_clk);
    #1;
    cmd_valid = 1'b0;
    @(posedge aq_clk);
    #1;
    chk("rst_t2.iorq_low_in_t2", 32'(aq_iorq_n), 32'd0);
    aq_rst_n = 1'b0;
    #1;
    chk("rst_t2.async_strobes_oe",
        32'({aq_mreq_n, aq_iorq_n, aq_rd_n, aq_wr_n, aq_data_oe}), 32'b11110);
    @(posedge aq_clk);
    #1;
    aq_rst_n = 1'b1;
    chk("rst_t2.ready_after_release", 32'(cmd_ready), 32'd1);
    rsp_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge aq_clk);
      #1;
      if (rsp_valid) rsp_seen++;
    end
    chk("rst_t2.no_rsp", 32'(rsp_seen), 32'd0);
    chk("rst_t2.lo_page", 32'(lo_page), 32'd0);

    for (int k = 0; k < 12; k++) begin
      run_vec(k, vecs[k]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
